// File: rtl/multi_axis_profile_gen.sv
// N-axis jerk/accel/velocity/position integrator with time-multiplexed update, step/dir
// pulse generation and controlled abort deceleration.
module multi_axis_profile_gen #(
    parameter int AXES     = 4,
    parameter int X_W      = 64,
    parameter int V_W      = 32,
    parameter int STEP_BIT = 32,
    parameter int STEP_LEN = 8,
    localparam int IDX_W   = (AXES > 1) ? $clog2(AXES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             acc_step,
    input  logic             abort,
    input  logic             load,
    input  logic [IDX_W-1:0] axis_sel,
    input  logic             set_x,
    input  logic             set_v,
    input  logic             set_a,
    input  logic             set_j,
    input  logic [X_W-1:0]   x_val,
    input  logic [V_W-1:0]   v_val,
    input  logic [V_W-1:0]   a_val,
    input  logic [V_W-1:0]   j_val,
    input  logic [V_W-1:0]   abort_a_val,
    input  logic [IDX_W-1:0] rd_sel,
    output logic [X_W-1:0]   rd_x,
    output logic [V_W-1:0]   rd_v,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic [AXES-1:0]  stopped,
    output logic [AXES-1:0]  step,
    output logic [AXES-1:0]  dir
);
    localparam int CNT_W = $clog2(STEP_LEN + 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SWEEP = 2'd1, ST_DONE = 2'd2} state_t;

    state_t                state_r, state_s;
    logic [IDX_W-1:0]      idx_r;
    logic                  pending_r, pending_s, set_ovr_s, overrun_s;
    logic                  overrun_r, busy_r, done_r;
    logic signed [X_W-1:0] x_r [AXES];
    logic signed [V_W-1:0] v_r [AXES];
    logic signed [V_W-1:0] a_r [AXES];
    logic signed [V_W-1:0] j_r [AXES];
    logic [CNT_W-1:0]      cnt_r [AXES];
    logic [AXES-1:0]       step_r, dir_r, stopped_s;
    logic [X_W-1:0]        rd_x_r;
    logic [V_W-1:0]        rd_v_r;
    logic signed [X_W-1:0] x_o_s, x_n_s;
    logic signed [V_W-1:0] v_o_s, a_o_s, j_o_s, v_n_s, a_n_s, j_n_s, a_ab_s, v_sum_s;
    logic                  upd_en_s, stop_s, step_hit_s, dir_s;

    // Sweep sequencing, single-deep tick pending and overrun detection
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r;
        set_ovr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (acc_step) state_s = ST_SWEEP;
                else          state_s = ST_IDLE;
            end
            ST_SWEEP: begin
                if (acc_step && pending_r)  set_ovr_s = 1'b1;
                else if (acc_step)          pending_s = 1'b1;
                else                        pending_s = pending_r;
                if (idx_r == IDX_W'(AXES - 1)) state_s = ST_DONE;
                else                           state_s = ST_SWEEP;
            end
            ST_DONE: begin
                if (pending_r) begin
                    state_s   = ST_SWEEP;
                    pending_s = 1'b0;
                    set_ovr_s = acc_step;
                end else if (acc_step) begin
                    state_s = ST_SWEEP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                pending_s = 1'b0;
            end
        endcase
        if (clr_overrun) overrun_s = 1'b0;
        else             overrun_s = overrun_r | set_ovr_s;
    end

    // Control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            idx_r     <= {IDX_W{1'b0}};
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            overrun_r <= overrun_s;
            busy_r    <= (state_s == ST_SWEEP);
            done_r    <= (state_s == ST_DONE);
            if (state_r == ST_SWEEP) idx_r <= idx_r + IDX_W'(1);
            else                     idx_r <= {IDX_W{1'b0}};
        end
    end

    // Shared integrator for the axis in the current sweep slot
    always_comb begin
        upd_en_s = (state_r == ST_SWEEP);
        x_o_s    = x_r[idx_r];
        v_o_s    = v_r[idx_r];
        a_o_s    = a_r[idx_r];
        j_o_s    = j_r[idx_r];
        x_n_s    = x_o_s + X_W'(v_o_s);
        a_ab_s   = {V_W{1'b0}};
        v_sum_s  = {V_W{1'b0}};
        stop_s   = 1'b0;
        if (abort) begin
            if (v_o_s[V_W-1])                   a_ab_s = abort_a_val;
            else if (v_o_s != {V_W{1'b0}})      a_ab_s = {V_W{1'b0}} - abort_a_val;
            else                                a_ab_s = {V_W{1'b0}};
            v_sum_s = v_o_s + a_ab_s;
            // zero crossing or landing on zero ends the deceleration
            stop_s  = (v_sum_s == {V_W{1'b0}}) || (v_sum_s[V_W-1] != v_o_s[V_W-1]);
            j_n_s   = {V_W{1'b0}};
            a_n_s   = stop_s ? {V_W{1'b0}} : a_ab_s;
            v_n_s   = stop_s ? {V_W{1'b0}} : v_sum_s;
        end else begin
            j_n_s = j_o_s;
            a_n_s = a_o_s + j_o_s;
            v_n_s = v_o_s + a_o_s;
        end
        step_hit_s = x_o_s[STEP_BIT] ^ x_n_s[STEP_BIT];
        dir_s      = (x_n_s > x_o_s);
    end

    // Per-axis state: sweep update first, host load overrides selected fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < AXES; i++) begin
                x_r[i]   <= {X_W{1'b0}};
                v_r[i]   <= {V_W{1'b0}};
                a_r[i]   <= {V_W{1'b0}};
                j_r[i]   <= {V_W{1'b0}};
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            step_r <= {AXES{1'b0}};
            dir_r  <= {AXES{1'b0}};
        end else begin
            for (int i = 0; i < AXES; i++) begin
                if (upd_en_s && (idx_r == IDX_W'(i))) begin
                    x_r[i] <= x_n_s;
                    v_r[i] <= v_n_s;
                    a_r[i] <= a_n_s;
                    j_r[i] <= j_n_s;
                end
                if (load && (axis_sel == IDX_W'(i))) begin
                    if (set_x) x_r[i] <= x_val;
                    if (set_v) v_r[i] <= v_val;
                    if (set_a) a_r[i] <= a_val;
                    if (set_j) j_r[i] <= j_val;
                end
                if (upd_en_s && (idx_r == IDX_W'(i)) && step_hit_s) begin
                    step_r[i] <= 1'b1;
                    dir_r[i]  <= dir_s;
                    cnt_r[i]  <= CNT_W'(STEP_LEN - 1);
                end else if (cnt_r[i] != {CNT_W{1'b0}}) begin
                    cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                end else begin
                    step_r[i] <= 1'b0;
                end
            end
        end
    end

    // Registered readback port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_x_r <= {X_W{1'b0}};
            rd_v_r <= {V_W{1'b0}};
        end else if ({1'b0, rd_sel} < (IDX_W + 1)'(AXES)) begin
            rd_x_r <= x_r[rd_sel];
            rd_v_r <= v_r[rd_sel];
        end else begin
            rd_x_r <= {X_W{1'b0}};
            rd_v_r <= {V_W{1'b0}};
        end
    end

    // Standstill flags straight from stored state
    always_comb begin
        for (int i = 0; i < AXES; i++) begin
            stopped_s[i] = (v_r[i] == {V_W{1'b0}}) && (a_r[i] == {V_W{1'b0}});
        end
    end

    assign rd_x    = rd_x_r;
    assign rd_v    = rd_v_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign overrun = overrun_r;
    assign stopped = stopped_s;
    assign step    = step_r;
    assign dir     = dir_r;
endmodule

// File: tb/tb_multi_axis_profile_gen.sv
// Directed self-checking bench for multi_axis_profile_gen (4 axes, step on bit 8).
module tb_multi_axis_profile_gen;
    logic        clk, reset, acc_step, abort, load, set_x, set_v, set_a, set_j, clr_overrun;
    logic [1:0]  axis_sel, rd_sel;
    logic [63:0] x_val, rd_x;
    logic [31:0] v_val, a_val, j_val, abort_a_val, rd_v;
    logic        busy, done, overrun;
    logic [3:0]  stopped, step, dir;
    int          total, bad;
    logic [63:0] rx;
    logic [31:0] rv;

    multi_axis_profile_gen #(.AXES(4), .X_W(64), .V_W(32), .STEP_BIT(8), .STEP_LEN(8)) dut (
        .clk(clk), .reset(reset), .acc_step(acc_step), .abort(abort), .load(load),
        .axis_sel(axis_sel), .set_x(set_x), .set_v(set_v), .set_a(set_a), .set_j(set_j),
        .x_val(x_val), .v_val(v_val), .a_val(a_val), .j_val(j_val),
        .abort_a_val(abort_a_val), .rd_sel(rd_sel), .rd_x(rd_x), .rd_v(rd_v),
        .busy(busy), .done(done), .overrun(overrun), .clr_overrun(clr_overrun),
        .stopped(stopped), .step(step), .dir(dir));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        acc_step = 0; abort = 0; load = 0; set_x = 0; set_v = 0; set_a = 0; set_j = 0;
        clr_overrun = 0; axis_sel = 0; rd_sel = 0; x_val = 0; v_val = 0; a_val = 0;
        j_val = 0; abort_a_val = 0;
        reset = 1'b1;
        clk1(); clk1();
        reset = 1'b0;
        clk1();
    endtask

    task automatic load_axis(input logic [1:0] ax, input logic sx, input logic sv,
                             input logic sa, input logic sj, input logic [63:0] xv,
                             input logic [31:0] vv, input logic [31:0] av, input logic [31:0] jv);
        axis_sel = ax; set_x = sx; set_v = sv; set_a = sa; set_j = sj;
        x_val = xv; v_val = vv; a_val = av; j_val = jv; load = 1'b1;
        clk1();
        load = 1'b0; set_x = 0; set_v = 0; set_a = 0; set_j = 0;
    endtask

    task automatic tick_and_wait();
        int n;
        acc_step = 1'b1;
        clk1();
        acc_step = 1'b0;
        n = 0;
        while (!done && n < 20) begin clk1(); n++; end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL tick_timeout done=%b want=1", done); end
        clk1();
    endtask

    task automatic read_axis(input logic [1:0] ax, output logic [63:0] xo, output logic [31:0] vo);
        rd_sel = ax;
        clk1();
        xo = rd_x;
        vo = rd_v;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_ovr got=%b want=0", overrun); end
        total++; if (step !== 4'h0) begin bad++; $display("FAIL rst_step got=%h want=0", step); end
        total++; if (dir !== 4'h0) begin bad++; $display("FAIL rst_dir got=%h want=0", dir); end
        total++; if (stopped !== 4'hF) begin bad++; $display("FAIL rst_stopped got=%h want=f", stopped); end
        total++; if (rd_x !== 64'd0) begin bad++; $display("FAIL rst_rdx got=%h want=0", rd_x); end
        total++; if (rd_v !== 32'd0) begin bad++; $display("FAIL rst_rdv got=%h want=0", rd_v); end
    endtask

    task automatic test_single_step();
        do_reset();
        load_axis(2'd2, 0, 1, 0, 0, 64'd0, 32'd256, 32'd0, 32'd0);
        acc_step = 1'b1;
        clk1();
        acc_step = 1'b0;
        for (int k = 0; k < 13; k++) begin
            total++;
            if (busy !== (k < 4)) begin bad++; $display("FAIL t1_busy k=%0d got=%b", k, busy); end
            total++;
            if (done !== (k == 4)) begin bad++; $display("FAIL t1_done k=%0d got=%b", k, done); end
            total++;
            if (step !== ((k >= 3 && k < 11) ? 4'b0100 : 4'b0000))
                begin bad++; $display("FAIL t1_step k=%0d got=%b", k, step); end
            if (k == 3) begin
                total++;
                if (dir[2] !== 1'b1) begin bad++; $display("FAIL t1_dir got=%b want=1", dir[2]); end
            end
            clk1();
        end
        read_axis(2'd2, rx, rv);
        total++; if (rx !== 64'd256) begin bad++; $display("FAIL t1_x got=%0d want=256", rx); end
        total++; if (rv !== 32'd256) begin bad++; $display("FAIL t1_v got=%0d want=256", rv); end
    endtask

    task automatic test_accel();
        do_reset();
        load_axis(2'd0, 0, 0, 1, 1, 64'd0, 32'd0, 32'd1, 32'd0);
        for (int k = 0; k < 3; k++) tick_and_wait();
        read_axis(2'd0, rx, rv);
        total++; if (rx !== 64'd3) begin bad++; $display("FAIL t2a_x got=%0d want=3", rx); end
        total++; if (rv !== 32'd3) begin bad++; $display("FAIL t2a_v got=%0d want=3", rv); end
        do_reset();
        load_axis(2'd0, 0, 0, 0, 1, 64'd0, 32'd0, 32'd0, 32'd1);
        for (int k = 0; k < 3; k++) tick_and_wait();
        read_axis(2'd0, rx, rv);
        total++; if (rx !== 64'd1) begin bad++; $display("FAIL t2j_x got=%0d want=1", rx); end
        total++; if (rv !== 32'd3) begin bad++; $display("FAIL t2j_v got=%0d want=3", rv); end
        tick_and_wait();
        read_axis(2'd0, rx, rv);
        total++; if (rv !== 32'd6) begin bad++; $display("FAIL t2j_a3 v=%0d want=6", rv); end
        total++; if (rx !== 64'd4) begin bad++; $display("FAIL t2j_x4 got=%0d want=4", rx); end
        total++; if (stopped !== 4'b1110) begin bad++; $display("FAIL t2_stopped got=%b", stopped); end
    endtask

    task automatic test_abort();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'd70; exp_v[1] = 32'd40; exp_v[2] = 32'd10; exp_v[3] = 32'd0;
        do_reset();
        load_axis(2'd1, 0, 1, 0, 0, 64'd0, 32'd100, 32'd0, 32'd0);
        total++; if (stopped !== 4'b1101) begin bad++; $display("FAIL t3_run got=%b", stopped); end
        abort_a_val = 32'd30;
        abort = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick_and_wait();
            read_axis(2'd1, rx, rv);
            total++;
            if (rv !== exp_v[k]) begin bad++; $display("FAIL t3_v k=%0d got=%0d want=%0d", k, rv, exp_v[k]); end
        end
        total++; if (rx !== 64'd220) begin bad++; $display("FAIL t3_x got=%0d want=220", rx); end
        total++; if (stopped !== 4'hF) begin bad++; $display("FAIL t3_stop got=%b", stopped); end
        tick_and_wait();
        read_axis(2'd1, rx, rv);
        total++; if (rv !== 32'd0 || stopped !== 4'hF)
            begin bad++; $display("FAIL t3_hold v=%0d stopped=%b", rv, stopped); end
        abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        int dones;
        do_reset();
        load_axis(2'd0, 0, 1, 0, 0, 64'd0, 32'd1, 32'd0, 32'd0);
        acc_step = 1'b1;
        clk1(); clk1();
        acc_step = 1'b0;
        dones = 0;
        for (int k = 0; k < 14; k++) begin if (done) dones++; clk1(); end
        total++; if (dones != 2) begin bad++; $display("FAIL t4_dones got=%0d want=2", dones); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL t4_noovr got=%b", overrun); end
        read_axis(2'd0, rx, rv);
        total++; if (rx !== 64'd2) begin bad++; $display("FAIL t4_x got=%0d want=2", rx); end
        acc_step = 1'b1;
        clk1(); clk1(); clk1();
        acc_step = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL t4_ovr got=%b want=1", overrun); end
        for (int k = 0; k < 14; k++) clk1();
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL t4_sticky got=%b want=1", overrun); end
        clr_overrun = 1'b1;
        clk1();
        clr_overrun = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL t4_clr got=%b want=0", overrun); end
    endtask

    task automatic test_load_slot();
        do_reset();
        load_axis(2'd3, 1, 1, 1, 0, 64'd0, 32'd5, 32'd2, 32'd0);
        acc_step = 1'b1;
        clk1();
        acc_step = 1'b0;
        clk1(); clk1(); clk1();
        axis_sel = 2'd3; set_v = 1'b1; v_val = 32'd1000; load = 1'b1;
        clk1();
        load = 1'b0; set_v = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL t5_done got=%b want=1", done); end
        clk1();
        read_axis(2'd3, rx, rv);
        total++; if (rv !== 32'd1000) begin bad++; $display("FAIL t5_v got=%0d want=1000", rv); end
        total++; if (rx !== 64'd5) begin bad++; $display("FAIL t5_x got=%0d want=5", rx); end
        tick_and_wait();
        read_axis(2'd3, rx, rv);
        total++; if (rx !== 64'd1005) begin bad++; $display("FAIL t5_x2 got=%0d want=1005", rx); end
        total++; if (rv !== 32'd1002) begin bad++; $display("FAIL t5_v2 got=%0d want=1002", rv); end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        load_axis(2'd0, 1, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 32'd0, 32'd0);
        acc_step = 1'b1;
        clk1();
        acc_step = 1'b0;
        clk1();
        total++; if (step !== 4'b0001) begin bad++; $display("FAIL t6_step got=%b want=0001", step); end
        total++; if (dir[0] !== 1'b1) begin bad++; $display("FAIL t6_dir got=%b want=1", dir[0]); end
        for (int k = 0; k < 6; k++) clk1();
        read_axis(2'd0, rx, rv);
        total++; if (rx !== 64'd0) begin bad++; $display("FAIL t6_wrap got=%h want=0", rx); end
        load_axis(2'd1, 0, 1, 0, 0, 64'd0, 32'd7, 32'd0, 32'd0);
        acc_step = 1'b1;
        clk1(); clk1();
        acc_step = 1'b0;
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_rbusy got=%b want=0", busy); end
        total++; if (stopped !== 4'hF) begin bad++; $display("FAIL t6_rstop got=%b want=f", stopped); end
        total++; if (rd_x !== 64'd0 || rd_v !== 32'd0)
            begin bad++; $display("FAIL t6_rrd x=%h v=%h want=0", rd_x, rd_v); end
        clk1();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            total++;
            if (busy !== 1'b0 || done !== 1'b0)
                begin bad++; $display("FAIL t6_pend k=%0d busy=%b done=%b want=0", k, busy, done); end
            clk1();
        end
        total++; if (step !== 4'h0 || dir !== 4'h0 || overrun !== 1'b0)
            begin bad++; $display("FAIL t6_rout step=%b dir=%b ovr=%b", step, dir, overrun); end
        read_axis(2'd1, rx, rv);
        total++; if (rv !== 32'd0) begin bad++; $display("FAIL t6_rv1 got=%0d want=0", rv); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        test_reset();
        test_single_step();
        test_accel();
        test_abort();
        test_back_to_back();
        test_load_slot();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
